// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide RAM port between instruction fetch and load/store.
// Each request is split into per-byte RAM cycles; MEM wins over IF when both ask in IDLE.
module mem_port_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic              if_done_o,
    output logic [31:0]       if_inst_o,
    output logic              if_busy_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_len_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic              mem_done_o,
    output logic [31:0]       mem_rdata_o,
    output logic              mem_busy_o,
    input  logic [7:0]        ram_din_i,
    output logic [7:0]        ram_dout_o,
    output logic [ADDR_W-1:0] ram_a_o,
    output logic              ram_wr_o
);

    typedef enum logic [2:0] {IDLE, RD_IF, RD_MEM, WR_MEM, DONE} state_t;

    state_t            state, state_nx;
    logic [2:0]        cnt, cnt_nx;
    logic [ADDR_W-1:0] base;
    logic [1:0]        len_q;
    logic              we_q;
    logic              own_mem;
    logic [31:0]       wdata_q;
    logic [31:0]       buf_q;
    logic [31:0]       inst_q;
    logic [31:0]       rdata_q;
    logic [2:0]        nbytes;
    logic              rd_st;
    logic              accept;
    logic [1:0]        cap_idx;

    // len 2 is not a legal size and is served as a full word
    assign nbytes  = (len_q == 2'd0) ? 3'd1 : (len_q == 2'd1) ? 3'd2 : 3'd4;
    assign rd_st   = (state == RD_IF) || (state == RD_MEM);
    assign accept  = (state == IDLE) && (state_nx != IDLE);
    assign cap_idx = cnt[1:0] - 2'd1;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                cnt_nx = 3'd0;
                if (mem_req_i)
                    state_nx = mem_we_i ? WR_MEM : RD_MEM;
                else if (if_req_i && !if_flush_i)
                    state_nx = RD_IF;
            end
            RD_IF, RD_MEM: begin
                if (state == RD_IF && if_flush_i) begin
                    state_nx = IDLE;
                    cnt_nx   = 3'd0;
                end else if (cnt == nbytes) begin
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt + 3'd1;
                end
            end
            WR_MEM: begin
                if (cnt == nbytes - 3'd1)
                    state_nx = DONE;
                else
                    cnt_nx = cnt + 3'd1;
            end
            DONE: begin
                state_nx = IDLE;
                cnt_nx   = 3'd0;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 3'd0;
            end
        endcase
    end

    always_comb begin
        ram_a_o    = '0;
        ram_wr_o   = 1'b0;
        ram_dout_o = 8'h00;
        if (rd_st) begin
            // While frozen, keep presenting the address whose byte is still owed,
            // so ram_din_i carries that byte again in the cycle rdy returns.
            if (!rdy && cnt != 3'd0)
                ram_a_o = base + ADDR_W'(cnt - 3'd1);
            else if (cnt < nbytes)
                ram_a_o = base + ADDR_W'(cnt);
        end else if (state == WR_MEM) begin
            ram_a_o    = base + ADDR_W'(cnt);
            ram_wr_o   = rdy && !rst;
            ram_dout_o = wdata_q[{cnt[1:0], 3'b000} +: 8];
        end
    end

    assign if_done_o   = (state == DONE) && !own_mem && rdy && !rst && !if_flush_i;
    assign mem_done_o  = (state == DONE) && own_mem && rdy && !rst;
    assign if_inst_o   = ((state == DONE) && !own_mem && !if_flush_i) ? buf_q : inst_q;
    assign mem_rdata_o = ((state == DONE) && own_mem && !we_q) ? buf_q : rdata_q;
    assign if_busy_o   = if_req_i && !if_done_o;
    assign mem_busy_o  = mem_req_i && !mem_done_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            base    <= '0;
            len_q   <= 2'd0;
            we_q    <= 1'b0;
            own_mem <= 1'b0;
            wdata_q <= 32'h0;
            buf_q   <= 32'h0;
            inst_q  <= 32'h0;
            rdata_q <= 32'h0;
        end else if (rdy) begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                buf_q <= 32'h0;
                if (state_nx == RD_IF) begin
                    base    <= if_addr_i;
                    len_q   <= 2'd3;
                    we_q    <= 1'b0;
                    own_mem <= 1'b0;
                end else begin
                    base    <= mem_addr_i;
                    len_q   <= mem_len_i;
                    we_q    <= mem_we_i;
                    own_mem <= 1'b1;
                    wdata_q <= mem_wdata_i;
                end
            end
            if (rd_st && cnt != 3'd0)
                buf_q[{cap_idx, 3'b000} +: 8] <= ram_din_i;
            if (state == DONE) begin
                if (own_mem && !we_q)
                    rdata_q <= buf_q;
                else if (!own_mem && !if_flush_i)
                    inst_q <= buf_q;
            end
        end
    end

endmodule
